// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Holds the FSM state encoding and the default geometry of the data RAM.
package ram_port_arbiter_pkg;

  localparam int AW_DEF       = 9;
  localparam int DW_DEF       = 16;
  localparam int MAX_LOCK_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// One requester port of the RAM arbiter.
// The requester drives the master side; the arbiter implements the slave side.
interface ram_port_arbiter_if #(
  parameter int AW = ram_port_arbiter_pkg::AW_DEF,
  parameter int DW = ram_port_arbiter_pkg::DW_DEF
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          lock;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, lock, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, lock, output gnt, rvalid, rdata);

endinterface

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Combinational two-way grant picker.
// In IDLE a lone requester wins and a tie goes to the port rr_ptr selects; an owner excludes the other port.
module rr_pick2
  import ram_port_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       ptr,
  input  arb_state_t state,
  output logic       gnt0,
  output logic       gnt1
);

  // NOTE: every output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      ST_IDLE: begin
        gnt0 = req0 & (~req1 | ~ptr);
        gnt1 = req1 & (~req0 |  ptr);
      end
      ST_OWN0: gnt0 = req0;
      ST_OWN1: gnt1 = req1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters, with a bounded burst lock.
// Commands to the RAM are registered; read data is returned two edges after the accept.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_port_arbiter_if.slave    p0,
  ram_port_arbiter_if.slave    p1,
  output logic                 m_wr_en,
  output logic [AW-1:0]        Addr,
  output logic [DW-1:0]        W_data,
  input  logic [DW-1:0]        R_data
);

  localparam int            CW       = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOCK - 1);
  // A lock of one grant is no lock at all, so ownership is never entered.
  localparam bit            LOCK_EN  = (MAX_LOCK > 1);

  arb_state_t    state, state_nxt;
  logic          rr_ptr, rr_ptr_nxt;
  logic [CW-1:0] lock_cnt, lock_cnt_nxt, cnt_inc;
  logic          pick0, pick1;
  logic          acc0, acc1, acc;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          iss_rd, iss_port;

  rr_pick2 u_pick (
    .req0  (p0.req),
    .req1  (p1.req),
    .ptr   (rr_ptr),
    .state (state),
    .gnt0  (pick0),
    .gnt1  (pick1)
  );

  assign p0.gnt = pick0 & rst_n;
  assign p1.gnt = pick1 & rst_n;
  assign acc0   = p0.req & p0.gnt;
  assign acc1   = p1.req & p1.gnt;
  assign acc    = acc0 | acc1;

  assign win_we    = acc1 ? p1.we    : p0.we;
  assign win_addr  = acc1 ? p1.addr  : p0.addr;
  assign win_wdata = acc1 ? p1.wdata : p0.wdata;
  assign cnt_inc   = lock_cnt + 1'b1;

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    rr_ptr_nxt   = rr_ptr;
    if (acc0)      rr_ptr_nxt = 1'b1;
    else if (acc1) rr_ptr_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (acc0 && p0.lock && LOCK_EN) begin
          state_nxt    = ST_OWN0;
          lock_cnt_nxt = '0;
        end else if (acc1 && p1.lock && LOCK_EN) begin
          state_nxt    = ST_OWN1;
          lock_cnt_nxt = '0;
        end
      end
      ST_OWN0: begin
        if (!acc0) begin
          state_nxt = ST_IDLE;
        end else begin
          lock_cnt_nxt = cnt_inc;
          if (!p0.lock || cnt_inc == CNT_LAST) state_nxt = ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!acc1) begin
          state_nxt = ST_IDLE;
        end else begin
          lock_cnt_nxt = cnt_inc;
          if (!p1.lock || cnt_inc == CNT_LAST) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // With no accept, Addr/W_data hold and the RAM sees a harmless read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr_en  <= 1'b0;
      Addr     <= '0;
      W_data   <= '0;
      iss_rd   <= 1'b0;
      iss_port <= 1'b0;
    end else if (acc) begin
      m_wr_en  <= win_we;
      Addr     <= win_addr;
      W_data   <= win_wdata;
      iss_rd   <= ~win_we;
      iss_port <= acc1;
    end else begin
      m_wr_en  <= 1'b0;
      iss_rd   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0.rvalid <= 1'b0;
      p0.rdata  <= '0;
      p1.rvalid <= 1'b0;
      p1.rdata  <= '0;
    end else begin
      p0.rvalid <= iss_rd & ~iss_port;
      p1.rvalid <= iss_rd &  iss_port;
      if (iss_rd && !iss_port) p0.rdata <= R_data;
      if (iss_rd &&  iss_port) p1.rdata <= R_data;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter against a 512x16 RAM model preloaded with 10*i.
// Accepted reads push their expected response to a scoreboard that is drained as rvalid arrives.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int AW       = 9;
  localparam int DW       = 16;
  localparam int MAX_LOCK = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) p0_bus ();
  ram_port_arbiter_if #(.AW(AW), .DW(DW)) p1_bus ();

  logic          m_wr_en;
  logic [AW-1:0] Addr;
  logic [DW-1:0] W_data;
  logic [DW-1:0] R_data;

  ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .p0      (p0_bus),
    .p1      (p1_bus),
    .m_wr_en (m_wr_en),
    .Addr    (Addr),
    .W_data  (W_data),
    .R_data  (R_data)
  );

  always #5 clk = ~clk;

  // RAM model: writes land on the negedge, reads are combinational.
  logic [DW-1:0] mem [512];
  bit            mem_ready = 1'b0;
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= DW'(10 * i);
      mem_ready <= 1'b1;
    end else if (m_wr_en) begin
      mem[Addr] <= W_data;
    end
  end
  assign R_data = mem[Addr];

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [512];
  int            cyc         = 0;
  int            vectors     = 0;
  int            miscompares = 0;
  logic          s_g0, s_g1, s_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit port, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic lock);
    if (!port) begin
      p0_bus.req = req; p0_bus.we = we; p0_bus.addr = addr; p0_bus.wdata = wdata; p0_bus.lock = lock;
    end else begin
      p1_bus.req = req; p1_bus.we = we; p1_bus.addr = addr; p1_bus.wdata = wdata; p1_bus.lock = lock;
    end
  endtask

  task automatic record(input bit port);
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w = port ? p1_bus.we    : p0_bus.we;
    a = port ? p1_bus.addr  : p0_bus.addr;
    d = port ? p1_bus.wdata : p0_bus.wdata;
    if (w) ref_mem[a] = d;
    else   sb.push_back('{port, ref_mem[a], cyc + 1});
  endtask

  // One clock cycle: check responses and grants at the negedge, log accepts at the posedge.
  task automatic step(input logic e0, input logic e1, input string tag);
    logic x0, x1;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
    x0 = (sb.size() > 0) && (sb[0].due == cyc) && !sb[0].port;
    x1 = (sb.size() > 0) && (sb[0].due == cyc) &&  sb[0].port;
    check({tag, " p0_rvalid"}, 32'(p0_bus.rvalid), 32'(x0));
    check({tag, " p1_rvalid"}, 32'(p1_bus.rvalid), 32'(x1));
    if (x0) check({tag, " p0_rdata"}, 32'(p0_bus.rdata), 32'(sb[0].data));
    if (x1) check({tag, " p1_rdata"}, 32'(p1_bus.rdata), 32'(sb[0].data));
    if (x0 || x1) void'(sb.pop_front());
    s_g0 = p0_bus.gnt;
    s_g1 = p1_bus.gnt;
    s_wr = m_wr_en;
    check({tag, " p0_gnt"}, 32'(s_g0), 32'(e0));
    check({tag, " p1_gnt"}, 32'(s_g1), 32'(e1));
    @(posedge clk);
    cyc++;
    if (p0_bus.req && s_g0) record(1'b0);
    if (p1_bus.req && s_g1) record(1'b1);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " m_wr_en"},   32'(m_wr_en),       32'd0);
    check({tag, " Addr"},      32'(Addr),          32'd0);
    check({tag, " W_data"},    32'(W_data),        32'd0);
    check({tag, " p0_rvalid"}, 32'(p0_bus.rvalid), 32'd0);
    check({tag, " p0_rdata"},  32'(p0_bus.rdata),  32'd0);
    check({tag, " p1_rvalid"}, 32'(p1_bus.rvalid), 32'd0);
    check({tag, " p1_rdata"},  32'(p1_bus.rdata),  32'd0);
    check({tag, " p0_gnt"},    32'(p0_bus.gnt),    32'd0);
    check({tag, " p1_gnt"},    32'(p1_bus.gnt),    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = DW'(10 * i);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single read from p0, granted immediately.
    drive(1'b0, 1'b1, 1'b0, 9'd5, '0, 1'b0);
    step(1'b1, 1'b0, "t1 grant");
    check("t1 Addr", 32'(Addr), 32'd5);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) step(1'b0, 1'b0, "t1 drain");

    // p1 write then read-back of the same address.
    drive(1'b1, 1'b1, 1'b1, 9'd4, 16'hBEEF, 1'b0);
    step(1'b0, 1'b1, "t3 write");
    drive(1'b1, 1'b1, 1'b0, 9'd4, '0, 1'b0);
    step(1'b0, 1'b1, "t3 read");
    check("t3 wr_en high", 32'(s_wr), 32'd1);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b0, "t3 drain");
    check("t3 wr_en low", 32'(s_wr), 32'd0);
    repeat (2) step(1'b0, 1'b0, "t3 resp");
    check("t3 p1_rdata", 32'(p1_bus.rdata), 32'hBEEF);

    // Both ports read continuously without lock: grants alternate.
    drive(1'b0, 1'b1, 1'b0, 9'd3, '0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 9'd7, '0, 1'b0);
    for (int i = 0; i < 6; i++) step(i % 2 == 0, i % 2 == 1, "t2 alternate");
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) step(1'b0, 1'b0, "t2 drain");

    // Locked p0 burst of 12 reads against a persistent p1 request.
    drive(1'b0, 1'b1, 1'b0, 9'd10, '0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 9'd20, '0, 1'b0);
    for (int k = 0; k < 13; k++) step(k != 8, k == 8, "t4 lock");
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b0, "t4 owner gone");
    step(1'b0, 1'b1, "t4 p1 next");
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) step(1'b0, 1'b0, "t4 drain");

    // Lock abandoned mid-burst.
    drive(1'b0, 1'b1, 1'b0, 9'd1, '0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 9'd2, '0, 1'b0);
    step(1'b1, 1'b0, "t6 enter lock");
    step(1'b1, 1'b0, "t6 owned");
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b0, "t6 drop");
    step(1'b0, 1'b1, "t6 p1 granted");
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) step(1'b0, 1'b0, "t6 drain");

    // Reset right after a p0 read accept: the response must never appear.
    drive(1'b0, 1'b1, 1'b0, 9'd6, '0, 1'b0);
    step(1'b1, 1'b0, "t5 accept");
    drive(1'b1, 1'b1, 1'b0, 9'd8, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t5 async reset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("t5 held reset");
    #2 rst_n = 1'b1;
    step(1'b1, 1'b0, "t5 first contention");
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) step(1'b0, 1'b0, "t5 drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
